pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Generic elastic pipeline-stage register for the pipelined RV32I core, intended to replace the fixed load-enable inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of parameterised width, for example a control word, PC and operands concatenated by the instantiating stage.
- Uses a valid/ready handshake with a one-entry skid buffer, so the upstream ready is fully registered.
- Adds flush and bubble semantics, which the older latches lack, for branch mispredict and halt squashing.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VAL, '0, payload value driven on out_data_o when out_valid_o=0, and loaded into both entries at reset or flush

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush_i  in  1  squash all held entries (mispredict/halt)
in_valid_i  in  1  upstream offers payload
in_ready_o  out  1  stage can accept this cycle (registered)
in_data_i  in  WIDTH  upstream payload
out_valid_o  out  1  stage presents valid payload downstream
out_ready_i  in  1  downstream accepts this cycle
out_data_o  out  WIDTH  payload to downstream stage

Behaviour:
- Storage:
  - main entry: main_q, main_v; drives out_data_o and out_valid_o directly.
  - skid entry: skid_q, skid_v.
- Handshake events:
  - Upstream transfer ("accept"): in_valid_i & in_ready_o.
  - Downstream transfer ("pop"): out_valid_o & out_ready_i.
  - in_ready_o = ~skid_v.
- States, encoded by {main_v, skid_v}:
  - EMPTY (00)
  - ONE (10)
  - FULL (11)
  - 01 is illegal and never reachable.
- Transitions, when flush_i=0 and rst=0:
  - EMPTY:
    - accept -> ONE, main_q <= in_data_i.
    - otherwise stay in EMPTY.
  - ONE:
    - accept & pop -> ONE, main_q <= in_data_i (full throughput).
    - accept & ~pop -> FULL, skid_q <= in_data_i.
    - ~accept & pop -> EMPTY.
    - otherwise stay in ONE.
  - FULL (in_ready_o=0, so no accept is possible):
    - pop -> ONE, main_q <= skid_q, skid_q <= RESET_VAL.
    - otherwise hold.
- Latency and throughput:
  - Accept at edge N gives out_valid_o=1 after edge N.
  - Sustained throughput is 1 item per cycle while out_ready_i=1.
- Ordering:
  - Strict FIFO; no payload is dropped or duplicated absent flush.
  - Payload is stable while out_valid_o=1 and out_ready_i=0.
- out_data_o = main_q when main_v=1, else RESET_VAL.
- rst (highest priority):
  - main_v=0, skid_v=0, main_q=skid_q=RESET_VAL.
  - Outputs after the edge: out_valid_o=0, in_ready_o=1, out_data_o=RESET_VAL.
  - Reset mid-transfer discards all held entries.
- flush_i=1 (priority below rst, above handshake):
  - Next state EMPTY, with the same values as rst.
  - An accept in the same cycle is discarded; upstream still sees in_ready_o=1 and counts it as consumed.
  - A pop in the same cycle is still a legal downstream transfer of the current main_q.
- No combinational path from out_ready_i to in_ready_o, or from in_valid_i to out_valid_o.

Optional Feature:
- Macro: PIPE_SKID_REG_PERF_EN.
- When defined:
  - Adds port stall_cnt_o, out, 32 bits.
  - Counts cycles with out_valid_o & ~out_ready_i.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst only, not by flush_i.
- When undefined:
  - The port and counter are absent.
  - Handshake behaviour is identical either way.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid_i=1, in_data_i=32'hDEAD_BEEF -> out_valid_o=0, out_data_o=0, in_ready_o=1; no item emerges after deassert until a new accept.
2. Streaming: out_ready_i=1, send 0x1,0x2,...,0x10 back-to-back -> out_data_o shows 0x1..0x10 on consecutive cycles starting 1 cycle after first accept, in_ready_o stays 1.
3. Backpressure/skid: send 0xA then 0xB, out_ready_i=0 -> FULL, in_ready_o=0 next cycle, out_data_o holds 0xA; raise out_ready_i -> 0xA, then 0xB, then in_ready_o=1.
4. Flush: FULL with 0xA/0xB, assert flush_i with in_valid_i=1, in_data_i=0xC -> next cycle out_valid_o=0, in_ready_o=1; 0xA, 0xB, 0xC never appear.
5. Random handshake: 1000 cycles random in_valid_i/out_ready_i, 50% each, incrementing payload -> scoreboard sees strictly increasing sequence without gaps; state 01 never observed.
6. PERF_EN: hold out_valid_o=1 with out_ready_i=0 for 7 cycles -> stall_cnt_o=7; assert flush_i -> count unchanged; assert rst -> 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a one-entry skid buffer, flush and a registered upstream ready.
// Optional stall-cycle counter on stall_cnt_o when PIPE_SKID_REG_PERF_EN is defined.
module pipe_skid_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
`ifdef PIPE_SKID_REG_PERF_EN
    output logic [31:0]      stall_cnt_o,
`endif
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q,   main_d;
    logic [WIDTH-1:0] skid_q,   skid_d;

    logic accept;
    logic pop;

    // Ready depends only on the skid flag, so there is no path from out_ready_i.
    assign in_ready_o  = ~skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_v_q ? main_q : RESET_VAL;

    assign accept = in_valid_i & ~skid_v_q;
    assign pop    = main_v_q & out_ready_i;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;

        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d   = RESET_VAL;
            skid_d   = RESET_VAL;
        end else begin
            case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept) begin
                        main_v_d = 1'b1;
                        main_d   = in_data_i;
                    end
                end
                2'b10: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        skid_v_d = 1'b1;
                        skid_d   = in_data_i;
                    end else if (pop) begin
                        main_v_d = 1'b0;
                    end
                end
                2'b11: begin
                    // Skid entry drains into main once the downstream takes the head.
                    if (pop) begin
                        skid_v_d = 1'b0;
                        main_d   = skid_q;
                        skid_d   = RESET_VAL;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    main_d   = RESET_VAL;
                    skid_d   = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= RESET_VAL;
            skid_q   <= RESET_VAL;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

`ifdef PIPE_SKID_REG_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Flush does not clear the counter; only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand-written reset/stream/perf sequences and a FIFO scoreboard.
module tb_pipe_skid_reg;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] in_data_i = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
`ifdef PIPE_SKID_REG_PERF_EN
    logic [31:0]  stall_cnt_o;
`endif

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
`ifdef PIPE_SKID_REG_PERF_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .out_data_o (out_data_o)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] sb_q[$];
    bit           chk_en  = 1'b0;
    bit           rand_ph = 1'b0;
    bit           last_vld = 1'b0;
    logic [W-1:0] last_pop = '0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes observed at the active edge drive a reference FIFO.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("pop_without_item", 32'd1, 32'd0);
                end else begin
                    check("pop_data", out_data_o, sb_q[0]);
                    void'(sb_q.pop_front());
                end
                if (rand_ph) begin
                    if (last_vld) check("seq_no_gap", out_data_o, last_pop + 32'd1);
                    last_pop = out_data_o;
                    last_vld = 1'b1;
                end
            end
            if (flush_i) sb_q.delete();
            else if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
        end
    end

    // Outputs must mirror the reference FIFO occupancy (rules out the 01 state too).
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_vs_model", 32'(out_valid_o), 32'(sb_q.size() > 0));
            check("ready_vs_model", 32'(in_ready_o), 32'(sb_q.size() < 2));
            check("data_vs_model", out_data_o, (sb_q.size() > 0) ? sb_q[0] : '0);
        end
    end

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [W-1:0] nxt;
        bit           acc;

        tbl[0]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 32'hA,  1'b1};
        tbl[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  1'b0};
        tbl[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  1'b0};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB,  1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 32'hA,  1'b1};
        tbl[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  1'b0};
        tbl[7]  = '{1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 32'h0,  1'b1};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};
        tbl[10] = '{1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 32'hD,  1'b1};
        tbl[11] = '{1'b1, 32'hE,  1'b1, 1'b1, 1'b0, 32'h0,  1'b1};
        tbl[12] = '{1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1};
        tbl[13] = '{1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 32'h66, 1'b1};
        tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h66, 1'b1};
        tbl[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  1'b1};

        // Reset held two cycles while upstream offers data.
        rst = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b1;
        step(); step();
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        rst = 1'b0; in_valid_i = 1'b0; chk_en = 1'b1;
        step(); step();
        check("post_rst_idle", 32'(out_valid_o), 32'd0);

        // Reset in the middle of a backpressured transfer discards both entries.
        in_valid_i = 1'b1; in_data_i = 32'h1; out_ready_i = 1'b0; step();
        in_data_i = 32'h2; step();
        check("midrst_full_ready", 32'(in_ready_o), 32'd0);
        rst = 1'b1; in_valid_i = 1'b0; step();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid_o), 32'd0);
        check("midrst_ready", 32'(in_ready_o), 32'd1);
        check("midrst_data", out_data_o, 32'd0);

        for (int i = 0; i < 16; i++) begin
            in_valid_i = tbl[i].iv; in_data_i = tbl[i].d;
            out_ready_i = tbl[i].ordy; flush_i = tbl[i].fl;
            step();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid_o), 32'(tbl[i].ov));
            check($sformatf("vec%0d_out_data", i), out_data_o, tbl[i].od);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready_o), 32'(tbl[i].ir));
        end
        flush_i = 1'b0; in_valid_i = 1'b0;

        // Back-to-back streaming at full throughput.
        out_ready_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_valid_i = 1'b1; in_data_i = 32'(k);
            step();
            check("stream_data", out_data_o, 32'(k));
            check("stream_ready", 32'(in_ready_o), 32'd1);
        end
        in_valid_i = 1'b0; step();
        check("stream_drained", 32'(out_valid_o), 32'd0);

        // Random handshake with an incrementing payload.
        nxt = 32'h100; rand_ph = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            out_ready_i = 1'($urandom_range(0, 1));
            in_data_i   = nxt;
            acc = in_valid_i && in_ready_o;
            step();
            if (acc) nxt = nxt + 32'd1;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        step(); step(); step();
        rand_ph = 1'b0;
        check("rand_drain_empty", 32'(sb_q.size()), 32'd0);
        check("rand_drain_valid", 32'(out_valid_o), 32'd0);
        check("rand_last_item", last_pop, nxt - 32'd1);

`ifdef PIPE_SKID_REG_PERF_EN
        rst = 1'b1; step(); rst = 1'b0;
        check("perf_rst_zero", stall_cnt_o, 32'd0);
        in_valid_i = 1'b1; in_data_i = 32'h77; out_ready_i = 1'b0; step();
        in_valid_i = 1'b0;
        repeat (7) step();
        check("perf_seven", stall_cnt_o, 32'd7);
        flush_i = 1'b1; out_ready_i = 1'b1; step();
        flush_i = 1'b0; step();
        check("perf_flush_keeps", stall_cnt_o, 32'd7);
        rst = 1'b1; step(); rst = 1'b0;
        check("perf_rst_clears", stall_cnt_o, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
